systolic_array_ctrl: RTL and testbench

Sequencer for the 4x4 weight-stationary `systolic_array`. It loads one weight tile through the north inputs, then streams activation vectors into the west inputs with per-row diagonal skew. It captures and deskews the row results from the east outputs and returns them to the host through a credit-protected result FIFO. It sits between the host/DMA streams and the array, and owns every array input port.

---
 rtl/systolic_array_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a ROWSxCOLS weight-stationary systolic array: weight load, skewed activation stream,
// deskewed result capture into a credit-protected FIFO. Define SA_CTRL_PERF_EN for perf_cycles/perf_stalls.
module systolic_array_ctrl #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DW         = 8,
    parameter int ACCW       = 24,
    parameter int ARRAY_LAT  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNTW       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNTW-1:0]      num_vec,
    output logic                 busy,
    output logic                 done,
`ifdef SA_CTRL_PERF_EN
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stalls,
`endif
    input  logic [COLS*DW-1:0]   w_data,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [ROWS*DW-1:0]   act_data,
    input  logic                 act_valid,
    output logic                 act_ready,
    output logic [ROWS*ACCW-1:0] res_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 sa_load_weight,
    output logic [COLS*DW-1:0]   sa_in_n,
    output logic [ROWS*ACCW-1:0] sa_in_w,
    input  logic [ROWS*ACCW-1:0] sa_out_e
);
    // state    | meaning
    // S_IDLE   | waiting for start
    // S_LOAD_W | accepting ROWS weight words
    // S_STREAM | accepting num_vec activation vectors
    // S_DRAIN  | waiting for in-flight results and an empty FIFO
    // S_DONE   | one-cycle done pulse
    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

    localparam int TAGN = ROWS + ARRAY_LAT;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WCW  = $clog2(ROWS + 1);

    state_t               state_q, state_d;
    logic [CNTW-1:0]      remain_q, remain_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic [CW-1:0]        inflight_q, inflight_d, count_q, count_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TAGN-1:0]      tag_q, tag_d;
    logic [ROWS*ACCW-1:0] mem_q [FIFO_DEPTH];
    logic [ROWS*ACCW-1:0] mem_d [FIFO_DEPTH];
    logic                 sa_load_weight_q, sa_load_weight_d;
    logic [COLS*DW-1:0]   sa_in_n_q, sa_in_n_d;
    logic [ROWS*ACCW-1:0] aligned;
    logic                 start_acc, w_acc, act_acc, push, pop, credit_ok;

    assign start_acc = start && (state_q == S_IDLE);
    assign w_acc     = w_valid && w_ready;
    assign act_acc   = act_valid && act_ready;
    assign push      = tag_q[TAGN-1];
    assign pop       = res_valid && res_ready;
    assign credit_ok = ((CW+1)'(count_q) + (CW+1)'(inflight_q)) < (CW+1)'(FIFO_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        wcnt_d   = wcnt_q;
        case (state_q)
            S_IDLE: if (start_acc) begin
                remain_d = num_vec;
                wcnt_d   = '0;
                state_d  = S_LOAD_W;
            end
            S_LOAD_W: if (w_acc) begin
                wcnt_d = wcnt_q + WCW'(1);
                if (wcnt_q == WCW'(ROWS - 1))
                    state_d = (remain_q == '0) ? S_DRAIN : S_STREAM;
            end
            S_STREAM: if (act_acc) begin
                remain_d = remain_q - CNTW'(1);
                if (remain_q == CNTW'(1)) state_d = S_DRAIN;
            end
            S_DRAIN: if (inflight_q == '0 && count_q == '0) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        w_ready   = (state_q == S_LOAD_W);
        act_ready = (state_q == S_STREAM) && credit_ok && (remain_q != '0);
        res_valid = (count_q != '0);
        res_data  = mem_q[rd_ptr_q];
    end

    always_comb begin
        sa_load_weight_d = w_acc;
        sa_in_n_d        = w_acc ? w_data : '0;
        tag_d            = {tag_q[TAGN-2:0], act_acc};
        inflight_d       = inflight_q + CW'(act_acc) - CW'(push);
        count_d          = count_q + CW'(push) - CW'(pop);
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        mem_d            = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = aligned;
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain_q         <= '0;
            wcnt_q           <= '0;
            inflight_q       <= '0;
            count_q          <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            tag_q            <= '0;
            sa_load_weight_q <= 1'b0;
            sa_in_n_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            remain_q         <= remain_d;
            wcnt_q           <= wcnt_d;
            inflight_q       <= inflight_d;
            count_q          <= count_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            tag_q            <= tag_d;
            sa_load_weight_q <= sa_load_weight_d;
            sa_in_n_q        <= sa_in_n_d;
            mem_q            <= mem_d;
        end
    end

    assign sa_load_weight = sa_load_weight_q;
    assign sa_in_n        = sa_in_n_q;

    // Lane r: r+1 skew stages in; ROWS-1-r deskew stages out, so every lane lines up with tag_q[TAGN-1].
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [ACCW-1:0] sk_q [r+1];
        logic [ACCW-1:0] sk_d [r+1];

        always_comb begin
            sk_d[0] = act_acc ? ACCW'(act_data[DW*r +: DW]) : '0;
            for (int s = 1; s <= r; s++) sk_d[s] = sk_q[s-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) for (int s = 0; s <= r; s++) sk_q[s] <= '0;
            else     sk_q <= sk_d;
        end

        assign sa_in_w[r*ACCW +: ACCW] = sk_q[r];

        if (r < ROWS - 1) begin : g_dsk
            localparam int N = ROWS - 1 - r;
            logic [ACCW-1:0] ds_q [N];
            logic [ACCW-1:0] ds_d [N];

            always_comb begin
                ds_d[0] = tag_q[r+ARRAY_LAT] ? sa_out_e[r*ACCW +: ACCW] : '0;
                for (int s = 1; s < N; s++) ds_d[s] = ds_q[s-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) for (int s = 0; s < N; s++) ds_q[s] <= '0;
                else     ds_q <= ds_d;
            end

            assign aligned[r*ACCW +: ACCW] = ds_q[N-1];
        end else begin : g_last
            assign aligned[r*ACCW +: ACCW] = sa_out_e[r*ACCW +: ACCW];
        end
    end

`ifdef SA_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (start_acc) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else begin
            if (busy && perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
            if ((state_q == S_STREAM) && act_valid && !act_ready && perf_stalls_q != '1)
                perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl; the array is stood in for by a LAT-cycle delay plus a per-lane offset.
module tb_systolic_array_ctrl;
    localparam int ROWS = 4, COLS = 4, DW = 8, ACCW = 24, LAT = 4, FD = 4, CNTW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CNTW-1:0]      num_vec;
    logic                 busy, done;
    logic [COLS*DW-1:0]   w_data;
    logic                 w_valid, w_ready;
    logic [ROWS*DW-1:0]   act_data;
    logic                 act_valid, act_ready;
    logic [ROWS*ACCW-1:0] res_data;
    logic                 res_valid, res_ready;
    logic                 sa_load_weight;
    logic [COLS*DW-1:0]   sa_in_n;
    logic [ROWS*ACCW-1:0] sa_in_w, sa_out_e;

    systolic_array_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .ACCW(ACCW),
        .ARRAY_LAT(LAT), .FIFO_DEPTH(FD), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .act_data(act_data), .act_valid(act_valid), .act_ready(act_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .sa_load_weight(sa_load_weight), .sa_in_n(sa_in_n),
        .sa_in_w(sa_in_w), .sa_out_e(sa_out_e)
    );

    always #5 clk = ~clk;

    // Array stand-in: out_e lane r = in_w lane r from LAT cycles earlier, plus 0x10*(r+1).
    logic [ROWS*ACCW-1:0] pipe_q [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
        else begin
            pipe_q[0] <= sa_in_w;
            for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end
    always_comb begin
        sa_out_e = '0;
        for (int r = 0; r < ROWS; r++)
            sa_out_e[r*ACCW +: ACCW] = pipe_q[LAT-1][r*ACCW +: ACCW] + ACCW'(16 * (r + 1));
    end

    typedef struct {
        logic [ROWS*DW-1:0]   act;
        logic [ROWS*ACCW-1:0] exp;
    } vec_t;
    vec_t tbl [8];

    int tests = 0, fails = 0, cyc = 0, done_cnt = 0, bp_stalls = 0;
    logic [ROWS*ACCW-1:0] got_q [$];
    logic [COLS*DW-1:0]   lw_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid && res_ready) got_q.push_back(res_data);
            if (done) done_cnt++;
            if (sa_load_weight) lw_q.push_back(sa_in_n);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        lw_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input int nv);
        num_vec = CNTW'(nv);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic load_weights();
        int g;
        w_valid = 1'b1;
        for (int k = 0; k < ROWS; k++) begin
            g = 0;
            w_data = (COLS*DW)'(32'h01010101 * (k + 1));
            while (!w_ready && g < 20) begin tick(); g++; end
            tick();
        end
        w_valid = 1'b0;
        w_data  = '0;
    endtask

    task automatic stream(input int base, input int n, input bit bubble, input bit bp);
        int idx, g;
        bit phase, prev_acc;
        logic [DW-1:0] prev_a0;
        idx = 0; g = 0; phase = 1'b1;
        while (idx < n && g < 400) begin
            act_data  = tbl[base+idx].act;
            act_valid = bubble ? phase : 1'b1;
            phase     = !phase;
            if (bp && !res_ready && act_valid && !act_ready) begin
                bp_stalls++;
                if (bp_stalls == 12) begin
                    check("bp_accepted_before_release", idx, 4);
                    res_ready = 1'b1;
                end
            end
            prev_acc = act_valid && act_ready;
            prev_a0  = act_data[DW-1:0];
            if (prev_acc) idx++;
            tick();
            g++;
            if (bubble) check("bubble_lane0", sa_in_w[ACCW-1:0], prev_acc ? ACCW'(prev_a0) : '0);
        end
        act_valid = 1'b0;
        check("stream_count", idx, n);
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (!done && g < 300) begin tick(); g++; end
        check("done_seen", done, 1'b1);
        tick();
        check("done_one_cycle", done, 1'b0);
        check("busy_fell", busy, 1'b0);
    endtask

    task automatic check_results(input string name, input int n);
        logic [ROWS*ACCW-1:0] v;
        check({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            v = (i < got_q.size()) ? got_q[i] : '1;
            check($sformatf("%s_res%0d", name, i), v, tbl[i].exp);
        end
    endtask

    task automatic run_single(input string name);
        int t, g;
        clear_mon();
        res_ready = 1'b1;
        do_start(1);
        load_weights();
        act_data  = tbl[0].act;
        act_valid = 1'b1;
        g = 0;
        while (!act_ready && g < 20) begin tick(); g++; end
        t = cyc;
        for (int r = 0; r < ROWS; r++) begin
            tick();
            act_valid = 1'b0;
            check($sformatf("%s_in_w_lane%0d", name, r), sa_in_w[r*ACCW +: ACCW], r + 1);
        end
        g = 0;
        while (!res_valid && g < 30) begin tick(); g++; end
        check({name, "_latency"}, cyc - t, 9);
        check({name, "_res_data"}, res_data, tbl[0].exp);
        wait_done();
        check_results(name, 1);
        check({name, "_done_pulses"}, done_cnt, 1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b0);
        check({name, "_w_ready"}, w_ready, 1'b0);
        check({name, "_act_ready"}, act_ready, 1'b0);
        check({name, "_res_valid"}, res_valid, 1'b0);
        check({name, "_sa_load_weight"}, sa_load_weight, 1'b0);
        check({name, "_sa_in_n"}, sa_in_n, '0);
        check({name, "_sa_in_w"}, sa_in_w, '0);
        check({name, "_res_data"}, res_data, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        // lane r expected = element r + 0x10*(r+1), elements zero-extended
        tbl[0] = '{32'h04030201, 96'h000044_000033_000022_000011};
        tbl[1] = '{32'h10203040, 96'h000050_000050_000050_000050};
        tbl[2] = '{32'hFFFFFFFF, 96'h00013F_00012F_00011F_00010F};
        tbl[3] = '{32'h00000000, 96'h000040_000030_000020_000010};
        tbl[4] = '{32'h80000001, 96'h0000C0_000030_000020_000011};
        tbl[5] = '{32'h12345678, 96'h000052_000064_000076_000088};
        tbl[6] = '{32'h0F0E0D0C, 96'h00004F_00003E_00002D_00001C};
        tbl[7] = '{32'hA5A5A5A5, 96'h0000E5_0000D5_0000C5_0000B5};

        rst = 1'b1; start = 1'b0; num_vec = '0; w_data = '0; w_valid = 1'b0;
        act_data = '0; act_valid = 1'b0; res_ready = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // weight load only
        clear_mon();
        do_start(0);
        check("wl_w_ready", w_ready, 1'b1);
        load_weights();
        wait_done();
        check("wl_pulses", lw_q.size(), ROWS);
        for (int k = 0; k < ROWS; k++)
            check($sformatf("wl_word%0d", k), (k < lw_q.size()) ? lw_q[k] : '1,
                  (COLS*DW)'(32'h01010101 * (k + 1)));
        check("wl_no_results", got_q.size(), 0);
        check("wl_done_pulses", done_cnt, 1);

        run_single("single");

        // back-pressure: FIFO credits cap acceptances at FD until results drain
        clear_mon();
        res_ready = 1'b0;
        bp_stalls = 0;
        do_start(8);
        load_weights();
        stream(0, 8, 1'b0, 1'b1);
        check("bp_stall_cycles", bp_stalls >= 12, 1'b1);
        res_ready = 1'b1;
        wait_done();
        check_results("bp", 8);
        check("bp_done_pulses", done_cnt, 1);

        // bubbles: alternate act_valid
        clear_mon();
        res_ready = 1'b1;
        do_start(3);
        load_weights();
        stream(0, 3, 1'b1, 1'b0);
        wait_done();
        check_results("bubble", 3);

        // reset in the middle of a stream
        clear_mon();
        res_ready = 1'b1;
        do_start(8);
        load_weights();
        act_data  = tbl[5].act;
        act_valid = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        act_valid = 1'b0;
        tick();
        check_all_zero("mid_rst");
        rst = 1'b0;
        tick(); tick();
        check("after_rst_res_valid", res_valid, 1'b0);
        check("after_rst_busy", busy, 1'b0);
        run_single("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
